// File: rtl/memory_sram.sv
// ---------------------------------------------------------------------------
// memory_sram
//
// Single-port synchronous word memory for the lab bus. A bus master presents
// address, data and control, and the block answers a read with data
// registered on the next rising edge of clk. One access per cycle is
// accepted with no handshake and no stall.
//
// Ports:
//   clk   in   1           system clock, all activity on the rising edge
//   rst   in   1           synchronous active-high reset
//   cen   in   1           chip enable: 1 = access this cycle, 0 = idle
//   wen   in   1           write enable, only meaningful while cen = 1
//   addr  in   ADDR_WIDTH  word address (every address is valid)
//   din   in   DATA_WIDTH  write data, ignored on read and idle cycles
//   dout  out  DATA_WIDTH  registered read data, 0 on every non-read cycle
//
// Parameters:
//   DATA_WIDTH  word width in bits (default 32)
//   ADDR_WIDTH  address width, depth = 2**ADDR_WIDTH words (default 5)
//
// Build option:
//   MEMORY_RESET_CLEAR_EN  when defined, a reset edge also clears every
//                          storage word to 0. When undefined, reset touches
//                          only dout, storage survives reset, and words
//                          that were never written hold unknown contents.
// ---------------------------------------------------------------------------
module memory_sram #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cen,
  input  logic                  wen,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_dout;

  logic w_write;
  logic w_read;

  // Reset outranks any access presented in the same cycle, so a request that
  // arrives together with rst is dropped rather than performed.
  assign w_write = !rst && cen && wen;
  assign w_read  = !rst && cen && !wen;

`ifdef MEMORY_RESET_CLEAR_EN
  // Storage with a clearing reset: every word returns to 0 on a reset edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_write) begin
      r_mem[addr] <= din;
    end
  end
`else
  // Storage without reset, which keeps it mappable onto a plain RAM macro.
  // Contents persist across rst.
  always_ff @(posedge clk) begin
    if (w_write) begin
      r_mem[addr] <= din;
    end
  end
`endif

  // Read port. dout carries data only on a read cycle and is driven to 0 on
  // reset, idle and write cycles. The array is sampled before this edge's
  // write lands, so a read sees the previously stored value.
  always_ff @(posedge clk) begin
    if (w_read) begin
      r_dout <= r_mem[addr];
    end else begin
      r_dout <= '0;
    end
  end

  assign dout = r_dout;

endmodule

// File: tb/tb_memory_sram.sv
// ---------------------------------------------------------------------------
// tb_memory_sram
//
// Self-checking bench for memory_sram. Each scenario task pushes the dout
// it expects for a cycle onto a scoreboard queue, drives that cycle, and
// then pops and compares the value once the registered output has settled.
// Honors MEMORY_RESET_CLEAR_EN in the same way as the design.
// ---------------------------------------------------------------------------
module tb_memory_sram;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int DEPTH = 2 ** AW;

  logic          clk;
  logic          rst;
  logic          cen;
  logic          wen;
  logic [AW-1:0] addr;
  logic [DW-1:0] din;
  logic [DW-1:0] dout;

  logic [DW-1:0] expQ [$];
  logic [DW-1:0] model [DEPTH];
  logic [DW-1:0] expV;

  int testsRun;
  int testsFailed;

  memory_sram #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .cen (cen),
    .wen (wen),
    .addr(addr),
    .din (din),
    .dout(dout)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drives one bus cycle on the falling edge, then returns just after the
  // rising edge that samples it, when dout is ready to be checked.
  task automatic applyStimulus(input logic r, input logic c, input logic w,
                               input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    rst  = r;
    cen  = c;
    wen  = w;
    addr = a;
    din  = d;
    @(posedge clk);
    #1;
  endtask

  // Holds rst for one edge, then one idle cycle. With the clearing reset
  // built in, the top word must also read back as 0.
  task automatic test_reset();
    expQ.push_back('0);
    applyStimulus(1'b1, 1'b0, 1'b0, '0, '0);
    expV = expQ.pop_front();
    testsRun++;
    if (dout !== expV) begin
      testsFailed++;
      $display("[TB] FAIL reset_dout: dout=%h expected=%h", dout, expV);
    end
    expQ.push_back('0);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 32'hFFFF_FFFF);
    expV = expQ.pop_front();
    testsRun++;
    if (dout !== expV) begin
      testsFailed++;
      $display("[TB] FAIL reset_idle: dout=%h expected=%h", dout, expV);
    end
`ifdef MEMORY_RESET_CLEAR_EN
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    expQ.push_back('0);
    applyStimulus(1'b0, 1'b1, 1'b0, 5'h1F, '0);
    expV = expQ.pop_front();
    testsRun++;
    if (dout !== expV) begin
      testsFailed++;
      $display("[TB] FAIL reset_clear_1F: dout=%h expected=%h", dout, expV);
    end
`endif
  endtask

  // Writes address i with value i for 0x00..0x0A. dout must stay at 0.
  task automatic test_seq_write();
    for (int i = 0; i <= 10; i++) begin
      model[i] = DW'(i);
      expQ.push_back('0);
      applyStimulus(1'b0, 1'b1, 1'b1, AW'(i), DW'(i));
      expV = expQ.pop_front();
      testsRun++;
      if (dout !== expV) begin
        testsFailed++;
        $display("[TB] FAIL seq_write[%0d]: dout=%h expected=%h", i, dout, expV);
      end
    end
  endtask

  // Runs one idle cycle, reads 0x00..0x0A back to back, then idles again.
  task automatic test_idle_readback();
    expQ.push_back('0);
    applyStimulus(1'b0, 1'b0, 1'b1, 5'h02, 32'h1234_5678);
    expV = expQ.pop_front();
    testsRun++;
    if (dout !== expV) begin
      testsFailed++;
      $display("[TB] FAIL idle_before_read: dout=%h expected=%h", dout, expV);
    end
    for (int i = 0; i <= 10; i++) begin
      expQ.push_back(DW'(i));
      applyStimulus(1'b0, 1'b1, 1'b0, AW'(i), 32'hA5A5_A5A5);
      expV = expQ.pop_front();
      testsRun++;
      if (dout !== expV) begin
        testsFailed++;
        $display("[TB] FAIL readback[%0d]: dout=%h expected=%h", i, dout, expV);
      end
    end
    expQ.push_back('0);
    applyStimulus(1'b0, 1'b0, 1'b0, 5'h0A, '0);
    expV = expQ.pop_front();
    testsRun++;
    if (dout !== expV) begin
      testsFailed++;
      $display("[TB] FAIL idle_after_read: dout=%h expected=%h", dout, expV);
    end
  endtask

  // Writes the top address, then reads it back on the very next cycle.
  task automatic test_read_after_write();
    model[31] = 32'hDEAD_BEEF;
    expQ.push_back('0);
    applyStimulus(1'b0, 1'b1, 1'b1, 5'h1F, 32'hDEAD_BEEF);
    expV = expQ.pop_front();
    testsRun++;
    if (dout !== expV) begin
      testsFailed++;
      $display("[TB] FAIL raw_write: dout=%h expected=%h", dout, expV);
    end
    expQ.push_back(32'hDEAD_BEEF);
    applyStimulus(1'b0, 1'b1, 1'b0, 5'h1F, '0);
    expV = expQ.pop_front();
    testsRun++;
    if (dout !== expV) begin
      testsFailed++;
      $display("[TB] FAIL raw_read: dout=%h expected=%h", dout, expV);
    end
  endtask

  // Overwrites one word, then presents a write with cen low that must be
  // ignored.
  task automatic test_overwrite_disable();
    applyStimulus(1'b0, 1'b1, 1'b1, 5'h03, 32'h5);
    applyStimulus(1'b0, 1'b1, 1'b1, 5'h03, 32'h7);
    model[3] = 32'h7;
    expQ.push_back(32'h7);
    applyStimulus(1'b0, 1'b1, 1'b0, 5'h03, '0);
    expV = expQ.pop_front();
    testsRun++;
    if (dout !== expV) begin
      testsFailed++;
      $display("[TB] FAIL overwrite_read: dout=%h expected=%h", dout, expV);
    end
    expQ.push_back('0);
    applyStimulus(1'b0, 1'b0, 1'b1, 5'h03, 32'hFF);
    expV = expQ.pop_front();
    testsRun++;
    if (dout !== expV) begin
      testsFailed++;
      $display("[TB] FAIL disabled_write_dout: dout=%h expected=%h", dout, expV);
    end
    expQ.push_back(32'h7);
    applyStimulus(1'b0, 1'b1, 1'b0, 5'h03, '0);
    expV = expQ.pop_front();
    testsRun++;
    if (dout !== expV) begin
      testsFailed++;
      $display("[TB] FAIL disabled_write_kept: dout=%h expected=%h", dout, expV);
    end
  endtask

  // Asserts rst together with a write. The write must be dropped, and the
  // storage must then be cleared or preserved depending on the build option.
  task automatic test_reset_mid();
    expQ.push_back('0);
    applyStimulus(1'b1, 1'b1, 1'b1, 5'h04, 32'h9);
    expV = expQ.pop_front();
    testsRun++;
    if (dout !== expV) begin
      testsFailed++;
      $display("[TB] FAIL reset_mid_dout: dout=%h expected=%h", dout, expV);
    end
`ifdef MEMORY_RESET_CLEAR_EN
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
`endif
    expQ.push_back(model[4]);
    applyStimulus(1'b0, 1'b1, 1'b0, 5'h04, '0);
    expV = expQ.pop_front();
    testsRun++;
    if (dout !== expV) begin
      testsFailed++;
      $display("[TB] FAIL reset_mid_addr4: dout=%h expected=%h", dout, expV);
    end
    expQ.push_back(model[3]);
    applyStimulus(1'b0, 1'b1, 1'b0, 5'h03, '0);
    expV = expQ.pop_front();
    testsRun++;
    if (dout !== expV) begin
      testsFailed++;
      $display("[TB] FAIL reset_mid_addr3: dout=%h expected=%h", dout, expV);
    end
  endtask

  // Fills every word with random data, then reads the whole array back to
  // back in shuffled order, with junk on din during the reads.
  task automatic test_back_to_back();
    int perm [DEPTH];
    int j;
    int t;
    logic [DW-1:0] d;
    for (int i = 0; i < DEPTH; i++) begin
      d = DW'($urandom);
      model[i] = d;
      applyStimulus(1'b0, 1'b1, 1'b1, AW'(i), d);
      perm[i] = i;
    end
    for (int i = DEPTH - 1; i > 0; i--) begin
      j = int'($urandom_range(i, 0));
      t = perm[i];
      perm[i] = perm[j];
      perm[j] = t;
    end
    for (int i = 0; i < DEPTH; i++) begin
      expQ.push_back(model[perm[i]]);
      applyStimulus(1'b0, 1'b1, 1'b0, AW'(perm[i]), DW'($urandom));
      expV = expQ.pop_front();
      testsRun++;
      if (dout !== expV) begin
        testsFailed++;
        $display("[TB] FAIL b2b_read[%0d]: dout=%h expected=%h", perm[i], dout, expV);
      end
    end
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    rst  = 1'b1;
    cen  = 1'b0;
    wen  = 1'b0;
    addr = '0;
    din  = '0;
    for (int i = 0; i < DEPTH; i++) model[i] = '0;

    test_reset();
    test_seq_write();
    test_idle_readback();
    test_read_after_write();
    test_overwrite_disable();
    test_reset_mid();
    test_back_to_back();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
